// File: rtl/clock_mode_ctrl_if.sv
// Button/tick inputs and edit-control outputs of the clock mode controller.
// master drives buttons and tick; slave is the controller.
interface clock_mode_ctrl_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       edit_en;
  logic       edit_sel;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       time_load;
  logic       alarm_load;
  logic       run_en;
  logic [2:0] state;

  modport master (
    output tick, btn_mode, btn_left, btn_right, btn_up, btn_down,
    input  edit_en, edit_sel, key_up, key_down, key_left, key_right,
           time_load, alarm_load, run_en, state
  );

  modport slave (
    input  tick, btn_mode, btn_left, btn_right, btn_up, btn_down,
    output edit_en, edit_sel, key_up, key_down, key_left, key_right,
           time_load, alarm_load, run_en, state
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Time-setting mode controller: button edge detection, RUN/EDIT/COMMIT FSM,
// key strobes, load strobes and idle timeout.
module clock_mode_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input logic              clk,
  input logic              rst,
  clock_mode_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {
    RUN          = 3'd0,
    EDIT_TIME    = 3'd1,
    COMMIT_TIME  = 3'd2,
    EDIT_ALARM   = 3'd3,
    COMMIT_ALARM = 3'd4
  } state_t;

  // Bit order {mode, up, down, left, right}: higher bit wins arbitration.
  logic [4:0]    btn_raw, sync1, sync2, prev, edge_det, win;
  state_t        st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    key_nxt;

  assign btn_raw  = {bus.btn_mode, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
  assign edge_det = sync2 & ~prev;
  assign bus.state = st;

  always_comb begin
    win = '0;
    if (edge_det[4])      win[4] = 1'b1;
    else if (edge_det[3]) win[3] = 1'b1;
    else if (edge_det[2]) win[2] = 1'b1;
    else if (edge_det[1]) win[1] = 1'b1;
    else if (edge_det[0]) win[0] = 1'b1;
  end

  always_comb begin
    st_nxt  = st;
    cnt_nxt = '0;
    key_nxt = '0;
    case (st)
      RUN: if (win[4]) st_nxt = EDIT_TIME;
      EDIT_TIME, EDIT_ALARM: begin
        cnt_nxt = cnt;
        // A winning edge takes precedence over a coincident timeout tick.
        if (win[4]) begin
          st_nxt  = (st == EDIT_TIME) ? COMMIT_TIME : COMMIT_ALARM;
          cnt_nxt = '0;
        end else if (|win) begin
          key_nxt = win[3:0];
          cnt_nxt = '0;
        end else if (bus.tick) begin
          if (cnt == CW'(TIMEOUT_TICKS - 1)) begin
            st_nxt  = RUN;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      COMMIT_TIME:  st_nxt = EDIT_ALARM;
      COMMIT_ALARM: st_nxt = RUN;
      default:      st_nxt = RUN;
    endcase
  end

  // Outputs are decoded from the next state so they line up with st.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1          <= '0;
      sync2          <= '0;
      prev           <= '0;
      st             <= RUN;
      cnt            <= '0;
      bus.key_up     <= 1'b0;
      bus.key_down   <= 1'b0;
      bus.key_left   <= 1'b0;
      bus.key_right  <= 1'b0;
      bus.edit_en    <= 1'b0;
      bus.edit_sel   <= 1'b0;
      bus.time_load  <= 1'b0;
      bus.alarm_load <= 1'b0;
      bus.run_en     <= 1'b1;
    end else begin
      sync1          <= btn_raw;
      sync2          <= sync1;
      prev           <= sync2;
      st             <= st_nxt;
      cnt            <= cnt_nxt;
      bus.key_up     <= key_nxt[3];
      bus.key_down   <= key_nxt[2];
      bus.key_left   <= key_nxt[1];
      bus.key_right  <= key_nxt[0];
      bus.edit_en    <= (st_nxt == EDIT_TIME) || (st_nxt == EDIT_ALARM);
      bus.edit_sel   <= (st_nxt == EDIT_ALARM) || (st_nxt == COMMIT_ALARM);
      bus.time_load  <= (st_nxt == COMMIT_TIME);
      bus.alarm_load <= (st_nxt == COMMIT_ALARM);
      bus.run_en     <= !((st_nxt == EDIT_TIME) || (st_nxt == COMMIT_TIME));
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: arbitration vector table plus
// hand-written latency, commit, timeout and reset sequences.
module tb_clock_mode_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  int kup, kdn, klf, krt, tl, al, multi_key, both_load;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(.TIMEOUT_TICKS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;    // {mode, up, down, left, right}
    logic [2:0] st;
    logic [3:0] keys;   // {up, down, left, right}
    logic [1:0] loads;  // {alarm, time}
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    kup = 0; kdn = 0; klf = 0; krt = 0; tl = 0; al = 0;
    multi_key = 0; both_load = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    kup += int'(bus.key_up);
    kdn += int'(bus.key_down);
    klf += int'(bus.key_left);
    krt += int'(bus.key_right);
    tl  += int'(bus.time_load);
    al  += int'(bus.alarm_load);
    if ((int'(bus.key_up) + int'(bus.key_down) + int'(bus.key_left) + int'(bus.key_right)) > 1)
      multi_key++;
    if (bus.time_load && bus.alarm_load) both_load++;
  endtask

  task automatic set_btn(input logic [4:0] b);
    bus.btn_mode  = b[4];
    bus.btn_up    = b[3];
    bus.btn_down  = b[2];
    bus.btn_left  = b[1];
    bus.btn_right = b[0];
  endtask

  task automatic tick_gap();
    repeat (7) step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic enter_edit();
    set_btn(5'b10000);
    repeat (2) step();
    set_btn(5'b00000);
    repeat (3) step();
    chk("enter_edit_state", int'(bus.state), 1);
  endtask

  initial begin
    int n;
    vt[0]  = '{5'b00000, 3'd0, 4'b0000, 2'b00};
    vt[1]  = '{5'b01000, 3'd0, 4'b0000, 2'b00};
    vt[2]  = '{5'b10000, 3'd1, 4'b0000, 2'b00};
    vt[3]  = '{5'b01000, 3'd1, 4'b1000, 2'b00};
    vt[4]  = '{5'b01010, 3'd1, 4'b1000, 2'b00};
    vt[5]  = '{5'b00111, 3'd1, 4'b0100, 2'b00};
    vt[6]  = '{5'b00011, 3'd1, 4'b0010, 2'b00};
    vt[7]  = '{5'b00001, 3'd1, 4'b0001, 2'b00};
    vt[8]  = '{5'b10100, 3'd3, 4'b0000, 2'b01};
    vt[9]  = '{5'b01010, 3'd3, 4'b1000, 2'b00};
    vt[10] = '{5'b10100, 3'd0, 4'b0000, 2'b10};

    rst = 1'b0;
    bus.tick = 1'b0;
    set_btn(5'b00000);
    clr();
    repeat (2) step();
    chk("rst_state", int'(bus.state), 0);
    chk("rst_run_en", int'(bus.run_en), 1);
    chk("rst_edit_en", int'(bus.edit_en), 0);
    chk("rst_edit_sel", int'(bus.edit_sel), 0);

    // Idle after reset release
    rst = 1'b1;
    clr();
    repeat (20) step();
    chk("idle_state", int'(bus.state), 0);
    chk("idle_run_en", int'(bus.run_en), 1);
    chk("idle_strobes", kup + kdn + klf + krt + tl + al, 0);

    // Mode latency and single key_up from a held button
    set_btn(5'b10000);
    repeat (2) step();
    chk("mode_lat_early", int'(bus.state), 0);
    step();
    chk("mode_lat_state", int'(bus.state), 1);
    chk("mode_lat_edit_en", int'(bus.edit_en), 1);
    chk("mode_lat_run_en", int'(bus.run_en), 0);
    repeat (2) step();
    set_btn(5'b00000);
    repeat (3) step();
    clr();
    set_btn(5'b01000);
    repeat (10) step();
    set_btn(5'b00000);
    repeat (3) step();
    chk("held_up_pulses", kup, 1);

    // Commit time then commit alarm
    clr();
    set_btn(5'b10000);
    repeat (2) step();
    chk("ct_pre_state", int'(bus.state), 1);
    step();
    chk("ct_state", int'(bus.state), 2);
    chk("ct_time_load", int'(bus.time_load), 1);
    chk("ct_run_en", int'(bus.run_en), 0);
    set_btn(5'b00000);
    step();
    chk("ea_state", int'(bus.state), 3);
    chk("ea_edit_sel", int'(bus.edit_sel), 1);
    chk("ea_run_en", int'(bus.run_en), 1);
    chk("ea_time_load", int'(bus.time_load), 0);
    repeat (3) step();
    set_btn(5'b10000);
    repeat (3) step();
    chk("ca_state", int'(bus.state), 4);
    chk("ca_alarm_load", int'(bus.alarm_load), 1);
    set_btn(5'b00000);
    step();
    chk("ca_after_state", int'(bus.state), 0);
    chk("ca_after_alarm_load", int'(bus.alarm_load), 0);
    chk("ct_ca_load_counts", tl * 10 + al, 11);
    repeat (3) step();

    // Arbitration table
    for (int i = 0; i < 11; i++) begin
      clr();
      set_btn(vt[i].btn);
      repeat (3) step();
      set_btn(5'b00000);
      repeat (4) step();
      chk($sformatf("vec%0d_state", i), int'(bus.state), int'(vt[i].st));
      chk($sformatf("vec%0d_keys", i),
          int'({kup > 0, kdn > 0, klf > 0, krt > 0}), int'(vt[i].keys));
      chk($sformatf("vec%0d_keycycles", i), kup + kdn + klf + krt, $countones(vt[i].keys));
      chk($sformatf("vec%0d_loads", i), int'({al > 0, tl > 0}), int'(vt[i].loads));
      chk($sformatf("vec%0d_onehot", i), multi_key + both_load, 0);
    end

    // Timeout after 3 ticks, nothing loaded
    enter_edit();
    clr();
    tick_gap();
    tick_gap();
    chk("to_after2_state", int'(bus.state), 1);
    tick_gap();
    chk("to_after3_state", int'(bus.state), 0);
    chk("to_run_en", int'(bus.run_en), 1);
    chk("to_no_load", tl + al, 0);

    // Key edge between ticks restarts the timeout
    repeat (3) step();
    enter_edit();
    clr();
    tick_gap();
    tick_gap();
    set_btn(5'b00001);
    repeat (2) step();
    set_btn(5'b00000);
    tick_gap();
    chk("tor_after3_state", int'(bus.state), 1);
    tick_gap();
    chk("tor_after4_state", int'(bus.state), 1);
    tick_gap();
    chk("tor_after5_state", int'(bus.state), 0);
    chk("tor_key_right", krt, 1);
    chk("tor_no_load", tl + al, 0);

    // Asynchronous reset during COMMIT_TIME
    repeat (3) step();
    enter_edit();
    set_btn(5'b10000);
    repeat (2) step();
    set_btn(5'b00000);
    n = 0;
    while (bus.state != 3'd2 && n < 10) begin
      step();
      n++;
    end
    chk("rc_reached_commit", int'(bus.state), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("rc_time_load", int'(bus.time_load), 0);
    chk("rc_state", int'(bus.state), 0);
    chk("rc_run_en", int'(bus.run_en), 1);

    // Button held across reset release gives exactly one edge
    set_btn(5'b10000);
    step();
    rst = 1'b1;
    repeat (4) step();
    chk("held_rst_state", int'(bus.state), 1);
    repeat (5) step();
    chk("held_rst_still", int'(bus.state), 1);
    set_btn(5'b00000);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Mode controller for the digital clock's time-setting path. It turns raw, debounced push-button levels into single-cycle key pulses, and steps a mode FSM through RUN → EDIT_TIME → EDIT_ALARM → RUN. It drives the edit-enable, cursor and up/down strobes of the time-edit datapath, freezes the time counter while time is being edited, and issues one-cycle load strobes to commit edited values into the time or alarm registers. An idle timeout aborts editing without committing.

## Interface
- TIMEOUT_TICKS, default 10: number of `tick` pulses without any key edge before an edit is aborted.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- tick  input  1  one-cycle timebase pulse, 1 Hz, synchronous to clk.
- btn_mode, btn_left, btn_right, btn_up, btn_down  input  1 each  debounced button levels, asynchronous to clk.
- edit_en  output  1  high in EDIT_TIME and EDIT_ALARM; drives the edit datapath enable.
- edit_sel  output  1  target of the edit: 0 = time, 1 = alarm.
- key_up, key_down, key_left, key_right  output  1 each  one-cycle key strobes, gated by edit_en.
- time_load  output  1  one-cycle strobe; commit the edited value into the time registers.
- alarm_load  output  1  one-cycle strobe; commit the edited value into the alarm registers.
- run_en  output  1  time counter enable; low in EDIT_TIME and COMMIT_TIME.
- state  output  3  encoded FSM state, for the display: RUN=0, EDIT_TIME=1, COMMIT_TIME=2, EDIT_ALARM=3, COMMIT_ALARM=4.

## Operation
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then a previous-value register.
  - An edge is sync2 & ~prev (rising edges only). Releases and held levels generate nothing.
- Edge arbitration within one cycle: mode > up > down > left > right. Only the winning edge has any effect; the others are dropped, not queued.
- FSM:
  - RUN: mode edge → EDIT_TIME. Key edges are ignored (no strobes).
  - EDIT_TIME: mode edge → COMMIT_TIME. Timeout → RUN with no load. Other winning edges drive the matching key_* strobe.
  - COMMIT_TIME: lasts 1 cycle, time_load=1, then unconditionally → EDIT_ALARM. Edges arriving in this cycle are dropped.
  - EDIT_ALARM: mode edge → COMMIT_ALARM. Timeout → RUN with no load. Key strobes as in EDIT_TIME.
  - COMMIT_ALARM: lasts 1 cycle, alarm_load=1, then unconditionally → RUN.
  - Unused state encodes 5–7 → RUN on the next edge.
- Outputs are registered: each is a function of the registered state, or a registered strobe.
  - edit_sel=1 only in EDIT_ALARM and COMMIT_ALARM.
  - time_load and alarm_load are never high together.
  - At most one key_* is high in any cycle.
- Timeout counter, width clog2(TIMEOUT_TICKS+1):
  - Cleared on entry to any EDIT state and on any winning edge while in EDIT.
  - Increments on `tick` while in an EDIT state.
  - When the count equals TIMEOUT_TICKS-1 and `tick`=1, the FSM goes to RUN and the counter clears.
  - If a key edge and the timeout tick land in the same cycle, the edge wins: the counter clears and the FSM stays in EDIT.
  - Held at 0 outside the EDIT states.

## Timing
- Reset values: state=RUN, edit_en=0, edit_sel=0, run_en=1, all key_* / time_load / alarm_load = 0, synchronizers and prev registers = 0, timeout counter = 0.
- Reset is asynchronous: asserting rst mid-commit cancels the load strobe immediately.
- A button held across reset release produces one edge after release.
- Latency:
  - A button rising before clk edge k appears in sync2 after edge k+1.
  - The edge is detected combinationally in the cycle after edge k+1.
  - key_* is registered and is high for exactly one cycle after edge k+2.
  - The state change on a mode edge also becomes visible after edge k+2.
- run_en falls in the same cycle that state becomes EDIT_TIME. It rises in the same cycle that state becomes EDIT_ALARM, or RUN on a timeout.
- A timeout from EDIT_TIME re-enables counting with the unedited time; nothing is loaded.
- Minimum time between accepted mode edges: 1 cycle, but COMMIT states swallow edges arriving during them.

## Test plan
- Reset, then release rst and run 20 cycles with no buttons pressed → state=0, run_en=1, and all strobes stay 0.
- From RUN, pulse btn_mode (high for 5 cycles) → state=1 and edit_en=1 exactly 3 edges after assertion; then btn_up held for 10 cycles → exactly one key_up pulse.
- In EDIT_TIME, press btn_mode → state 2 for exactly 1 cycle with time_load=1 and run_en=0; next cycle state=3, edit_sel=1, run_en=1. Press btn_mode again → alarm_load=1 for 1 cycle, then state=0.
- In EDIT_ALARM, assert btn_up and btn_left on the same cycle → only key_up pulses. Assert btn_mode and btn_down together → state advances and no key_down pulses.
- TIMEOUT_TICKS=3 in EDIT_TIME with no keys, tick every 8 cycles:
  - After the 3rd tick → state=0, no time_load.
  - Repeat with btn_right pressed between ticks 2 and 3 → no timeout until 3 further ticks.
- Assert rst (low) during COMMIT_TIME → time_load drops immediately, state=0, run_en=1.
